// File: rtl/sram_1rw_port_ctrl.sv
// rtl/sram_1rw_port_ctrl.sv - zero-fill, request strobing and credit-protected read return for a 1RW SRAM macro
// Response FIFO is a separate module so the credit logic in the top stays readable.

module sram_1rw_port_resp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Entries need no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

module sram_1rw_port_ctrl #(
  parameter int BITS       = 2848,
  parameter int WORD_DEPTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_in,
  output logic                  init_done,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wd,
  input  logic [BITS-1:0]       req_mask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BITS-1:0]       resp_data,
  output logic                  resp_err,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_w_mask,
  input  logic [BITS-1:0]       sram_rd
);

  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam int OW  = CW + 1;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [OW-1:0]         CREDITS     = OW'(RESP_DEPTH);
  localparam logic [AW1-1:0]        DEPTH_LIMIT = AW1'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(WORD_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_pending;
  logic                  rd_oor;

  logic [CW-1:0]         fifo_count;
  logic [BITS:0]         fifo_head;
  logic [BITS:0]         fifo_push_data;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  addr_in_range;
  logic                  req_fire;
  logic [OW-1:0]         occupancy;

  assign addr_in_range = {1'b0, req_addr} < DEPTH_LIMIT;
  assign resp_valid    = !rst_in && (fifo_count != '0);
  assign fifo_pop      = resp_valid && resp_ready;

  // Credits cover the read still in flight, so a full FIFO also stalls writes.
  assign occupancy = OW'(fifo_count) + OW'(rd_pending) - OW'(fifo_pop);
  assign req_ready = !rst_in && (state == ST_RUN) && (occupancy < CREDITS);
  assign req_fire  = req_valid && req_ready;
  assign init_done = !rst_in && (state == ST_RUN);

  assign fifo_push      = !rst_in && rd_pending;
  assign fifo_push_data = {(rd_oor ? {BITS{1'b0}} : sram_rd), rd_oor};
  assign resp_data      = resp_valid ? fifo_head[BITS:1] : {BITS{1'b0}};
  assign resp_err       = resp_valid && fifo_head[0];

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state      <= ST_INIT;
      init_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_oor     <= 1'b0;
    end else begin
      rd_pending <= req_fire && !req_we;
      rd_oor     <= !addr_in_range;
      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) state <= ST_RUN;
        end
        ST_RUN:  ;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Idle strobes are forced to zero so no undriven value reaches the macro pins.
  always_comb begin
    sram_ce     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wd     = '0;
    sram_w_mask = '0;
    if (!rst_in) begin
      if (state == ST_INIT) begin
        sram_ce     = 1'b1;
        sram_we     = 1'b1;
        sram_addr   = init_cnt;
        sram_w_mask = '1;
      end else if (req_fire && addr_in_range) begin
        sram_ce     = 1'b1;
        sram_we     = req_we;
        sram_addr   = req_addr;
        sram_wd     = req_wd;
        sram_w_mask = req_mask;
      end
    end
  end

  sram_1rw_port_resp_fifo #(
    .W     (BITS + 1),
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_in    (rst_in),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// tb/tb_sram_1rw_port_ctrl.sv - directed self-checking bench for sram_1rw_port_ctrl
// Second instance uses WORD_DEPTH=20 to reach the out-of-range path.

module tb_sram_1rw_port_ctrl;

  localparam int BITS = 2848;
  localparam int WD   = 32;
  localparam int AW   = 5;
  localparam int RD   = 2;
  localparam int WD_B = 20;
  localparam logic [BITS-1:0] GARBAGE = {89{32'hDEADBEEF}};

  logic clk = 1'b0;
  logic rst_in = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic            init_done, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
  logic [AW-1:0]   req_addr, sram_addr;
  logic [BITS-1:0] req_wd, req_mask, resp_data, sram_wd, sram_w_mask, sram_rd;
  logic            sram_ce, sram_we;

  logic            init_done_b, req_valid_b, req_ready_b, req_we_b, resp_valid_b, resp_ready_b, resp_err_b;
  logic [AW-1:0]   req_addr_b, sram_addr_b;
  logic [BITS-1:0] req_wd_b, req_mask_b, resp_data_b, sram_wd_b, sram_w_mask_b, sram_rd_b;
  logic            sram_ce_b, sram_we_b;

  logic [BITS-1:0] mem [WD];
  logic [BITS-1:0] rd_q;

  always #5 clk = ~clk;

  sram_1rw_port_ctrl #(.BITS(BITS), .WORD_DEPTH(WD), .ADDR_WIDTH(AW), .RESP_DEPTH(RD)) dut (
    .clk(clk), .rst_in(rst_in), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wd(req_wd), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wd(sram_wd),
    .sram_w_mask(sram_w_mask), .sram_rd(sram_rd)
  );

  sram_1rw_port_ctrl #(.BITS(BITS), .WORD_DEPTH(WD_B), .ADDR_WIDTH(AW), .RESP_DEPTH(RD)) dut_b (
    .clk(clk), .rst_in(rst_in), .init_done(init_done_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b), .req_addr(req_addr_b),
    .req_wd(req_wd_b), .req_mask(req_mask_b),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_data(resp_data_b), .resp_err(resp_err_b),
    .sram_ce(sram_ce_b), .sram_we(sram_we_b), .sram_addr(sram_addr_b), .sram_wd(sram_wd_b),
    .sram_w_mask(sram_w_mask_b), .sram_rd(sram_rd_b)
  );

  // Write-first macro model; read data is garbage except in the cycle after a read.
  always @(posedge clk) begin
    if (sram_ce && sram_we)
      mem[sram_addr] <= (mem[sram_addr] & ~sram_w_mask) | (sram_wd & sram_w_mask);
    if (sram_ce && !sram_we) rd_q <= mem[sram_addr];
    else                     rd_q <= GARBAGE;
  end
  assign sram_rd   = rd_q;
  assign sram_rd_b = GARBAGE;

  always @(posedge clk) begin
    if (!rst_in && dut.fifo_push && !dut.fifo_pop && dut.fifo_count == 2'(RD)) begin
      failures++;
      $display("FAIL fifo_overflow push while full count=%0d limit=%0d", dut.fifo_count, RD);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [BITS-1:0] pat(input int a);
    logic [31:0] w;
    w = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {89{w}};
  endfunction

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({init_done, req_ready, resp_valid, resp_err, sram_ce, sram_we} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got done=%b rdy=%b rv=%b err=%b ce=%b we=%b want all 0",
               init_done, req_ready, resp_valid, resp_err, sram_ce, sram_we);
    end
    checks++;
    if (sram_addr !== '0 || sram_wd !== '0 || sram_w_mask !== '0) begin
      failures++;
      $display("FAIL reset_strobes got addr=%0d wd_lo=%h mask_lo=%h want 0", sram_addr, sram_wd[31:0], sram_w_mask[31:0]);
    end
    checks++;
    if (resp_data !== '0) begin
      failures++;
      $display("FAIL reset_resp_data got lo=%h want 0", resp_data[31:0]);
    end
    checks++;
    if (sram_ce_b !== 1'b0 || init_done_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_b got ce=%b done=%b want 0 0", sram_ce_b, init_done_b);
    end
    @(posedge clk); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_init_sweep();
    for (int c = 0; c < WD; c++) begin
      @(negedge clk);
      checks++;
      if (sram_ce !== 1'b1 || sram_we !== 1'b1 || sram_addr !== AW'(c) || sram_wd !== '0 ||
          sram_w_mask !== {BITS{1'b1}} || req_ready !== 1'b0 || init_done !== 1'b0 || resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL init_sweep cyc=%0d got ce=%b we=%b addr=%0d wd0=%b m1=%b rdy=%b done=%b rv=%b want 1 1 %0d 1 1 0 0 0",
                 c, sram_ce, sram_we, sram_addr, (sram_wd == '0), (sram_w_mask == {BITS{1'b1}}),
                 req_ready, init_done, resp_valid, c);
      end
      checks++;
      if (init_done_b !== 1'(c >= WD_B)) begin
        failures++;
        $display("FAIL init_done_b cyc=%0d got=%b want=%b", c, init_done_b, 1'(c >= WD_B));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || sram_ce !== 1'b0) begin
      failures++;
      $display("FAIL init_end got done=%b rdy=%b ce=%b want 1 1 0", init_done, req_ready, sram_ce);
    end
  endtask

  task automatic test_read_zero();
    @(posedge clk); #1;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd7; req_wd = '0; req_mask = '0;
    @(negedge clk);
    checks++;
    if (sram_ce !== 1'b1 || sram_we !== 1'b0 || sram_addr !== 5'd7 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL read7_issue got ce=%b we=%b addr=%0d rdy=%b want 1 0 7 1", sram_ce, sram_we, sram_addr, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read7_early got rv=%b want 0", resp_valid);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== '0 || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL read7_resp got rv=%b lo=%h zero=%b err=%b want 1 0 1 0", resp_valid, resp_data[31:0], (resp_data == '0), resp_err);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL read7_after got rv=%b want 0", resp_valid);
    end
  endtask

  task automatic test_write_mask();
    logic [BITS-1:0] exp_data;
    exp_data = {{(BITS-32){1'b0}}, 32'hA5A5A5A5};
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd3;
    req_wd = {356{8'hA5}}; req_mask = {{(BITS-32){1'b0}}, 32'hFFFFFFFF};
    @(negedge clk);
    checks++;
    if (sram_ce !== 1'b1 || sram_we !== 1'b1 || sram_w_mask !== req_mask || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr3_issue got ce=%b we=%b mask_ok=%b rdy=%b want 1 1 1 1", sram_ce, sram_we, (sram_w_mask == req_mask), req_ready);
    end
    @(posedge clk); #1;
    req_we = 1'b0; req_wd = '0; req_mask = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || sram_ce !== 1'b1 || sram_we !== 1'b0) begin
      failures++;
      $display("FAIL rd3_issue got rdy=%b ce=%b we=%b want 1 1 0", req_ready, sram_ce, sram_we);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== exp_data || resp_err !== 1'b0) begin
      failures++;
      $display("FAIL rd3_resp got rv=%b lo=%h match=%b err=%b want 1 a5a5a5a5 1 0", resp_valid, resp_data[31:0], (resp_data == exp_data), resp_err);
    end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < WD; a++) begin
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(a); req_wd = pat(a); req_mask = '1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
        failures++;
        $display("FAIL preload_ready addr=%0d got=%b want=1", a, req_ready);
      end
    end
    for (int cyc = 0; cyc < 66; cyc++) begin
      @(posedge clk); #1;
      req_valid = (cyc < 64); req_we = 1'b0; req_addr = AW'(cyc % WD); req_wd = '0; req_mask = '0;
      @(negedge clk);
      if (cyc < 64) begin
        checks++;
        if (req_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready cyc=%0d got=%b want=1", cyc, req_ready);
        end
      end
      if (cyc >= 2) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== pat((cyc - 2) % WD) || resp_err !== 1'b0) begin
          failures++;
          $display("FAIL b2b_resp idx=%0d got rv=%b lo=%h err=%b want 1 %h 0",
                   cyc - 2, resp_valid, resp_data[31:0], resp_err, pat((cyc - 2) % WD) >> 0 & 32'hFFFFFFFF);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drained got rv=%b want 0", resp_valid);
    end
  endtask

  task automatic test_backpressure();
    int qi;
    int ri;
    qi = 0;
    ri = 0;
    for (int cyc = 0; cyc < 40 && ri < 5; cyc++) begin
      @(posedge clk); #1;
      resp_ready = (cyc >= 8);
      req_valid = (qi < 5); req_we = 1'b0; req_addr = AW'(10 + qi);
      @(negedge clk);
      if (cyc >= 2 && cyc < 8) begin
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== pat(10) || resp_err !== 1'b0) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got rv=%b lo=%h err=%b want 1 %h 0", cyc, resp_valid, resp_data[31:0], resp_err, pat(10) & 32'hFFFFFFFF);
        end
      end
      if (cyc == 7) begin
        checks++;
        if (qi != RD || req_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_credit got accepted=%0d rdy=%b want %0d 0", qi, req_ready, RD);
        end
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (resp_data !== pat(10 + ri) || resp_err !== 1'b0) begin
          failures++;
          $display("FAIL bp_drain idx=%0d got lo=%h err=%b want %h 0", ri, resp_data[31:0], resp_err, pat(10 + ri) & 32'hFFFFFFFF);
        end
        ri++;
      end
      if (req_valid && req_ready) qi++;
    end
    checks++;
    if (ri != 5 || qi != 5) begin
      failures++;
      $display("FAIL bp_totals got resp=%0d req=%0d want 5 5", ri, qi);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic test_reset_midread();
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_accept got rdy=%b want 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_in = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || init_done !== 1'b0 || sram_ce !== 1'b0) begin
      failures++;
      $display("FAIL midrst_during got rv=%b done=%b ce=%b want 0 0 0", resp_valid, init_done, sram_ce);
    end
    @(posedge clk); #1;
    rst_in = 1'b0;
    test_init_sweep();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL midrst_noresp k=%0d got rv=%b want 0", k, resp_valid);
      end
    end
  endtask

  task automatic test_out_of_range();
    @(posedge clk); #1;
    resp_ready_b = 1'b1;
    req_valid_b = 1'b1; req_we_b = 1'b0; req_addr_b = 5'd25; req_wd_b = '0; req_mask_b = '0;
    @(negedge clk);
    checks++;
    if (sram_ce_b !== 1'b0 || req_ready_b !== 1'b1) begin
      failures++;
      $display("FAIL oor_issue got ce=%b rdy=%b want 0 1", sram_ce_b, req_ready_b);
    end
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    @(negedge clk);
    checks++;
    if (sram_ce_b !== 1'b0 || resp_valid_b !== 1'b0) begin
      failures++;
      $display("FAIL oor_t1 got ce=%b rv=%b want 0 0", sram_ce_b, resp_valid_b);
    end
    @(negedge clk);
    checks++;
    if (resp_valid_b !== 1'b1 || resp_err_b !== 1'b1 || resp_data_b !== '0) begin
      failures++;
      $display("FAIL oor_resp got rv=%b err=%b lo=%h zero=%b want 1 1 0 1", resp_valid_b, resp_err_b, resp_data_b[31:0], (resp_data_b == '0));
    end
    @(negedge clk);
    checks++;
    if (resp_valid_b !== 1'b0) begin
      failures++;
      $display("FAIL oor_after got rv=%b want 0", resp_valid_b);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wd = '0; req_mask = '0; resp_ready = 1'b1;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wd_b = '0; req_mask_b = '0; resp_ready_b = 1'b1;
    test_reset();
    test_init_sweep();
    test_read_zero();
    test_write_mask();
    test_back_to_back();
    test_backpressure();
    test_reset_midread();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_1rw_port_ctrl.md
Name: sram_1rw_port_ctrl

Overview:
Initiator-side controller for the single-port 1RW SRAM macro models in the xiangshan nangate45 flow. It zero-initialises the array after reset so no word is ever read as X. It then converts a valid/ready request stream (read or masked write) into macro ce/we/addr/wd/mask strobes. It captures read data in the single cycle it is valid and returns it through a credit-protected response FIFO.

Parameters:
BITS, 2848, data and mask width, equal to macro word width
WORD_DEPTH, 32, number of macro words
ADDR_WIDTH, 5, address width; WORD_DEPTH <= 2**ADDR_WIDTH
RESP_DEPTH, 2, response FIFO entries (>=2)

Ports:
clk  in  1  clock; sole clock domain
rst_in  in  1  synchronous active-high reset
init_done  out  1  high once the zero-fill sweep is complete
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  word address
req_wd  in  BITS  write data
req_mask  in  BITS  per-bit write enable
resp_valid  out  1  read response valid
resp_ready  in  1  response consumed when valid&&ready
resp_data  out  BITS  read data
resp_err  out  1  read was out of range (addr >= WORD_DEPTH)
sram_ce  out  1  macro chip enable
sram_we  out  1  macro write enable
sram_addr  out  ADDR_WIDTH  macro address
sram_wd  out  BITS  macro write data
sram_w_mask  out  BITS  macro write mask
sram_rd  in  BITS  macro read data; valid only in the cycle after a ce=1 read

Behaviour:
- Reset: the cycle rst_in is high, the FIFO empties and in-flight state clears. Outputs: init_done=0, req_ready=0, resp_valid=0, resp_err=0, resp_data=0, sram_ce=0, sram_we=0, sram_addr=0, sram_wd=0, sram_w_mask=0. Next state is INIT with counter=0.
- FSM states: INIT, RUN.
- INIT:
  - sram_ce=1, sram_we=1, sram_addr=counter, sram_wd=0, sram_w_mask=all ones, req_ready=0.
  - counter increments every cycle.
  - After the write to WORD_DEPTH-1 (exactly WORD_DEPTH cycles), go to RUN; init_done=1 from the first RUN cycle.
- RUN:
  - Macro strobes are combinational from the accepted request: sram_ce = req_valid && req_ready && addr_in_range; sram_we=req_we; sram_addr=req_addr; sram_wd=req_wd; sram_w_mask=req_mask.
  - When sram_ce=0, sram_we=0 and sram_wd/sram_w_mask/sram_addr are 0, so no X reaches the macro.
- Write: accepted in cycle T, committed at the T edge. There is no response. An out-of-range write is accepted and dropped silently.
- Read:
  - Accepted in cycle T; rd_pending register is set for T+1.
  - In T+1, sram_rd is pushed into the FIFO with err=0.
  - An out-of-range read issues no macro access. It pushes data=0, err=1 in T+1.
  - resp_valid is asserted from cycle T+2 (fixed 2-cycle latency when the FIFO is empty).
- Credit rule: req_ready = RUN && (fifo_count + rd_pending - (resp_valid && resp_ready)) < RESP_DEPTH.
  - This counts all requests, so a write may stall behind a full FIFO.
  - With resp_ready held high, one request per cycle is sustained indefinitely.
- Read-after-write to the same address in the next cycle returns the new data. The macro is write-first, and no bypass is needed.
- FIFO:
  - Circular, with pointers that wrap modulo RESP_DEPTH.
  - Push and pop in the same cycle keep the count unchanged.
  - Overflow is impossible by the credit rule. Asserting a push while full is a bench assertion failure.
- resp_data and resp_err are stable while resp_valid && !resp_ready.
- Reset mid-operation: a pending read's data is discarded. No response is ever produced for a pre-reset request. A full re-init sweep occurs.
- rst_in has priority over all other activity in the same cycle.

Test Plan:
- Release reset -> exactly 32 cycles of ce=1, we=1, addr 0..31, wd=0, mask=all-ones; init_done rises on cycle 33; req_ready=0 throughout INIT.
- After init, read addr 7 -> resp_valid 2 cycles later with resp_data=0, resp_err=0.
- Write addr 3 data=0xA5A5.. (all 2848 bits) with mask low 32 bits only, then read addr 3 -> bits[31:0] equal the written pattern and all other bits are 0.
- 64 back-to-back reads of addresses 0..31 twice, resp_ready=1 -> req_ready never drops; responses arrive in order, one per cycle, each matching the preloaded data.
- resp_ready=0 with 5 reads offered -> exactly RESP_DEPTH accepted, req_ready=0 after that, resp_data held stable; raising resp_ready drains in order and resumes acceptance.
- Read issued, rst_in asserted on the next cycle -> no resp_valid, FIFO empty, and a full INIT sweep repeats. With WORD_DEPTH=20, ADDR_WIDTH=5, a read of addr 25 -> resp_err=1, resp_data=0, sram_ce stays 0.
